// File: rtl/csa_sum_pipe_if.sv
// Beat interface for csa_sum_pipe: operand/tag input channel plus result channel.
// The master drives operands and out_ready; the slave (the pipeline) drives results.
interface csa_sum_pipe_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             mode;
    logic             first;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, c, mode, first, in_valid, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  a, b, c, mode, first, in_valid, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/csa_sum_pipe.sv
// Two-stage carry-save three-operand adder with an optional saturating accumulator.
// Stage 1 holds the carry-save pair; stage 2 resolves it and updates the accumulator.
// A stalled output freezes the whole pipe, so in_ready is simply the absence of a stall.
module csa_sum_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 8
) (
    input logic          clk,
    input logic          rst,
    csa_sum_pipe_if.slave bus
);
    localparam int unsigned SumW = WIDTH + 2;
    localparam logic [ACC_W-1:0] AccMax = '1;

    // Stage 1 state
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_s_q;
    logic [WIDTH-1:0] s1_cs_q;
    logic             s1_mode_q;
    logic             s1_first_q;

    // Stage 2 / output state
    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    // Next-state values for stage 2
    logic [SumW-1:0]  sum;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_d;
    logic             ovf_d;
    logic [ACC_W-1:0] data_d;

    logic stall;

    assign stall         = out_valid_q && !bus.out_ready;
    assign bus.in_ready  = !stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    // ovf only changes when a beat enters the output register, so the live flag
    // always matches the beat being presented.
    assign bus.out_ovf   = ovf_q;

    // Stage 1: capture the bitwise carry-save pair and tags of an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= '0;
            s1_cs_q    <= '0;
            s1_mode_q  <= 1'b0;
            s1_first_q <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_s_q     <= bus.a ^ bus.b ^ bus.c;
                s1_cs_q    <= (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
                s1_mode_q  <= bus.mode;
                s1_first_q <= bus.first;
            end
        end
    end

    // Stage 2 next state: resolve the carry-save pair and apply the beat's mode.
    always_comb begin
        sum     = SumW'(s1_s_q) + (SumW'(s1_cs_q) << 1);
        acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(sum);
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        data_d  = ACC_W'(sum);
        if (s1_mode_q) begin
            if (s1_first_q) begin
                acc_d = ACC_W'(sum);
                ovf_d = 1'b0;
            end else if (acc_sum[ACC_W]) begin
                acc_d = AccMax;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
            data_d = acc_d;
        end
    end

    // Stage 2 register: the accumulator moves only when a beat enters the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= data_d;
                acc_q      <= acc_d;
                ovf_q      <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_csa_sum_pipe.sv
// Self-checking bench for csa_sum_pipe: directed scenarios plus randomized traffic,
// all scored against an arithmetic reference model with an in-order result queue.
module tb_csa_sum_pipe;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned ACC_MAX = (1 << ACC_W) - 1;

    typedef struct {
        int unsigned data;
        bit          ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    csa_sum_pipe_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

    csa_sum_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int unsigned m_acc = 0;
    bit          m_ovf = 1'b0;
    exp_t        exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result of one accepted beat, straight from the arithmetic rules.
    task automatic model_accept(input int unsigned a, input int unsigned b, input int unsigned c,
                                input bit mode, input bit first);
        int unsigned sum;
        int unsigned tot;
        exp_t e;
        sum = a + b + c;
        if (!mode) begin
            e.data = sum;
        end else if (first) begin
            m_acc = sum;
            m_ovf = 1'b0;
            e.data = m_acc;
        end else begin
            tot = m_acc + sum;
            if (tot > ACC_MAX) begin
                m_acc = ACC_MAX;
                m_ovf = 1'b1;
            end else begin
                m_acc = tot;
            end
            e.data = m_acc;
        end
        e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive at the falling edge, score 1 ns later, then cross the rising edge.
    task automatic step(input bit iv, input int unsigned a, input int unsigned b,
                        input int unsigned c, input bit mode, input bit first,
                        input bit ordy, input bit do_rst);
        rst          = do_rst;
        bus.in_valid = iv;
        bus.a        = a[WIDTH-1:0];
        bus.b        = b[WIDTH-1:0];
        bus.c        = c[WIDTH-1:0];
        bus.mode     = mode;
        bus.first    = first;
        bus.out_ready = ordy;
        #1;
        if (!do_rst) begin
            check("in_ready", bus.in_ready, !(bus.out_valid && !ordy));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    check("out_data", bus.out_data, exp_q[0].data);
                    check("out_ovf", bus.out_ovf, exp_q[0].ovf);
                    if (ordy) void'(exp_q.pop_front());
                end
            end
            if (iv && bus.in_ready) model_accept(a, b, c, mode, first);
        end
        @(posedge clk);
        if (do_rst) begin
            exp_q.delete();
            m_acc = 0;
            m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic beat(input int unsigned a, input int unsigned b, input int unsigned c,
                        input bit mode, input bit first);
        step(1'b1, a, b, c, mode, first, 1'b1, 1'b0);
    endtask

    // Bounded drain: every outstanding result must emerge within a few cycles.
    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check("drain_outstanding", exp_q.size(), 0);
        idle(1'b1);
        check("idle_out_valid", bus.out_valid, 0);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
        bus.mode = 1'b0;
        bus.first = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // Mode 0 max operands; the result appears after the second rising edge.
        beat(15, 15, 15, 1'b0, 1'b0);
        check("lat_edge1_valid", bus.out_valid, 0);
        idle(1'b1);
        check("lat_edge2_valid", bus.out_valid, 1);
        check("lat_edge2_data", bus.out_data, 45);
        check("lat_edge2_ovf", bus.out_ovf, 0);
        drain();

        // Back-to-back accumulation into saturation, then a restart.
        for (int i = 0; i < 6; i++) beat(15, 15, 15, 1'b1, i == 0);
        beat(1, 2, 3, 1'b1, 1'b1);
        drain();
        check("restart_ovf", bus.out_ovf, 0);
        check("restart_data", bus.out_data, 6);

        // Backpressure: three beats, consumer stalls for four cycles.
        beat(1, 0, 0, 1'b0, 1'b0);
        beat(2, 0, 0, 1'b0, 1'b0);
        step(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 7, 7, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_hold_data", bus.out_data, 1);
        check("stall_in_ready", bus.in_ready, 0);
        drain();

        // Interleaved modes: mode 0 must not disturb the accumulator.
        beat(10, 0, 0, 1'b1, 1'b1);
        beat(3, 3, 3, 1'b0, 1'b1);
        beat(1, 1, 1, 1'b1, 1'b0);
        drain();
        check("interleave_last", bus.out_data, 13);

        // Reset with two beats in flight: nothing emerges, accumulator restarts from 0.
        beat(9, 9, 9, 1'b1, 1'b1);
        beat(4, 4, 4, 1'b1, 1'b0);
        do_reset();
        idle(1'b1);
        idle(1'b1);
        beat(2, 2, 2, 1'b1, 1'b0);
        drain();
        check("post_rst_acc", bus.out_data, 6);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 127) == 0);
        end
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
